// File: rtl/mac_operand_packer.sv
// Packs serial (data, weight) beats into MAX_MACS-lane vectors for the MAC array.
// Optional: define MAC_PACK_ZERO_FILL_EN to zero lanes >= num_macs during EMIT.
module mac_operand_packer #(
  parameter int MAX_MACS   = 64,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(MAX_MACS+1)-1:0]  cfg_len_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [DATA_WIDTH-1:0]          s_data_i,
  input  logic [DATA_WIDTH-1:0]          s_weight_i,
  input  logic                           s_last_i,
  output logic                           m_valid_o,
  output logic [$clog2(MAX_MACS+1)-1:0]  m_num_macs_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0] m_data_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0] m_weight_o,
  output logic                           cfg_err_o,
  output logic [CNT_W-1:0]               vec_cnt_o
);

  localparam int LW = $clog2(MAX_MACS+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                state;
  logic [LW-1:0]         cnt;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         num_q;
  logic                  err_q;
  logic [CNT_W-1:0]      vec_q;
  logic [DATA_WIDTH-1:0] data_q   [MAX_MACS];
  logic [DATA_WIDTH-1:0] weight_q [MAX_MACS];

  logic [LW-1:0] clamp_len;
  logic          cfg_bad;
  logic [LW-1:0] wr_idx;
  logic [LW-1:0] cnt_nxt;
  logic [LW-1:0] lim;
  logic          close;
  logic          acc;

  always_comb begin
    cfg_bad   = (cfg_len_i == '0) || (cfg_len_i > LW'(MAX_MACS));
    clamp_len = cfg_bad ? LW'(MAX_MACS) : cfg_len_i;
    wr_idx    = (state == IDLE) ? '0 : cnt;
    cnt_nxt   = wr_idx + 1'b1;
    lim       = (state == IDLE) ? clamp_len : len_q;
    close     = s_last_i | (cnt_nxt == lim);
    acc       = s_valid_i & s_ready_o;
  end

`ifdef MAC_PACK_ZERO_FILL_EN
  logic [MAX_MACS-1:0] mask_q;
  logic [MAX_MACS-1:0] mask_nxt;

  always_comb begin
    mask_nxt = '0;
    for (int i = 0; i < MAX_MACS; i++)
      mask_nxt[i] = LW'(i) < cnt_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mask_q <= '1;
    else if (acc && close)
      mask_q <= mask_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      num_q <= '0;
      err_q <= 1'b0;
      vec_q <= '0;
      for (int i = 0; i < MAX_MACS; i++) begin
        data_q[i]   <= '0;
        weight_q[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE, FILL: begin
          if (acc) begin
            for (int i = 0; i < MAX_MACS; i++) begin
              if (LW'(i) == wr_idx) begin
                data_q[i]   <= s_data_i;
                weight_q[i] <= s_weight_i;
              end
            end
            cnt <= cnt_nxt;
            if (state == IDLE) begin
              len_q <= clamp_len;
              if (cfg_bad)
                err_q <= 1'b1;
            end
            if (close) begin
              state <= EMIT;
              num_q <= cnt_nxt;
            end else begin
              state <= FILL;
            end
          end
        end
        EMIT: begin
          vec_q <= vec_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_ready_o    = ~rst & (state != EMIT);
  assign m_valid_o    = (state == EMIT);
  assign m_num_macs_o = num_q;
  assign cfg_err_o    = err_q;
  assign vec_cnt_o    = vec_q;

  for (genvar g = 0; g < MAX_MACS; g++) begin : g_lane
    logic keep;
`ifdef MAC_PACK_ZERO_FILL_EN
    assign keep = (state != EMIT) | mask_q[g];
`else
    assign keep = 1'b1;
`endif
    assign m_data_o[g*DATA_WIDTH +: DATA_WIDTH] =
      keep ? data_q[g] : '0;
    assign m_weight_o[g*DATA_WIDTH +: DATA_WIDTH] =
      keep ? weight_q[g] : '0;
  end

endmodule

// File: tb/tb_mac_operand_packer.sv
// Self-checking bench for mac_operand_packer: directed cases plus random
// streams checked against a lane-array reference model.
module tb_mac_operand_packer;

  logic         clk;
  logic         rst;
  logic [6:0]   cfg_len_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [7:0]   s_data_i;
  logic [7:0]   s_weight_i;
  logic         s_last_i;
  logic         m_valid_o;
  logic [6:0]   m_num_macs_o;
  logic [511:0] m_data_o;
  logic [511:0] m_weight_o;
  logic         cfg_err_o;
  logic [15:0]  vec_cnt_o;

  mac_operand_packer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_len_i    (cfg_len_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_data_i     (s_data_i),
    .s_weight_i   (s_weight_i),
    .s_last_i     (s_last_i),
    .m_valid_o    (m_valid_o),
    .m_num_macs_o (m_num_macs_o),
    .m_data_o     (m_data_o),
    .m_weight_o   (m_weight_o),
    .cfg_err_o    (cfg_err_o),
    .vec_cnt_o    (vec_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model
  logic [7:0]  md [64];
  logic [7:0]  mw [64];
  bit          in_vec;
  int          mcnt;
  int          mlen;
  bit          merr;
  logic [6:0]  exp_num;
  logic [15:0] exp_vec;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] packv(input bit wsel, input int n);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 64; i++)
      if (i < n) v[i*8 +: 8] = wsel ? mw[i] : md[i];
    return v;
  endfunction

  task automatic model_reset();
    in_vec  = 0;
    mcnt    = 0;
    mlen    = 0;
    merr    = 0;
    exp_num = '0;
    exp_vec = '0;
    for (int i = 0; i < 64; i++) begin
      md[i] = '0;
      mw[i] = '0;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 512'(m_valid_o), 512'(0));
    chk({tag, "_ready"}, 512'(s_ready_o), 512'(1));
    chk({tag, "_num"}, 512'(m_num_macs_o), 512'(exp_num));
    chk({tag, "_data"}, m_data_o, packv(0, 64));
    chk({tag, "_wt"}, m_weight_o, packv(1, 64));
    chk({tag, "_vcnt"}, 512'(vec_cnt_o), 512'(exp_vec));
    chk({tag, "_err"}, 512'(cfg_err_o), 512'(merr));
  endtask

  // Called at a negedge; drives one cycle of input and checks the result.
  task automatic step(input bit v, input logic [7:0] d, input logic [7:0] w,
                      input bit last, input logic [6:0] cfg,
                      output bit emitted);
    int n;
    s_valid_i  = v;
    s_data_i   = d;
    s_weight_i = w;
    s_last_i   = last;
    cfg_len_i  = cfg;
    @(negedge clk);
    emitted = 0;
    if (v) begin
      if (!in_vec) begin
        in_vec = 1;
        mcnt   = 0;
        if (cfg == 0 || cfg > 64) begin
          mlen = 64;
          merr = 1;
        end else begin
          mlen = int'(cfg);
        end
      end
      md[mcnt] = d;
      mw[mcnt] = w;
      mcnt++;
      if (mcnt == mlen || last) emitted = 1;
    end
    s_valid_i = 0;
    if (emitted) begin
`ifdef MAC_PACK_ZERO_FILL_EN
      n = mcnt;
`else
      n = 64;
`endif
      exp_num = 7'(mcnt);
      in_vec  = 0;
      chk("emit_valid", 512'(m_valid_o), 512'(1));
      chk("emit_ready", 512'(s_ready_o), 512'(0));
      chk("emit_num", 512'(m_num_macs_o), 512'(exp_num));
      chk("emit_data", m_data_o, packv(0, n));
      chk("emit_wt", m_weight_o, packv(1, n));
      chk("emit_vcnt", 512'(vec_cnt_o), 512'(exp_vec));
      chk("emit_err", 512'(cfg_err_o), 512'(merr));
      // a beat offered during EMIT must be ignored
      s_valid_i  = 1;
      s_data_i   = 8'(~d);
      s_weight_i = 8'(~w);
      s_last_i   = 1;
      @(negedge clk);
      s_valid_i = 0;
      s_last_i  = 0;
      exp_vec++;
      chk_quiet("post");
    end else begin
      chk_quiet("fill");
    end
  endtask

  task automatic idle(input int n);
    s_valid_i = 0;
    for (int i = 0; i < n; i++) @(negedge clk);
    chk_quiet("idle");
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    model_reset();
    chk("rst_ready", 512'(s_ready_o), 512'(0));
    chk("rst_valid", 512'(m_valid_o), 512'(0));
    chk("rst_num", 512'(m_num_macs_o), 512'(0));
    chk("rst_data", m_data_o, 512'(0));
    chk("rst_wt", m_weight_o, 512'(0));
    chk("rst_err", 512'(cfg_err_o), 512'(0));
    chk("rst_vcnt", 512'(vec_cnt_o), 512'(0));
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_rel_ready", 512'(s_ready_o), 512'(1));
  endtask

  bit e;
  bit got;
  int guard;
  logic [6:0] cfg;
  logic [7:0] d0;
  logic [7:0] w0;

  initial begin
    rst = 1;
    cfg_len_i = 7'd4;
    s_valid_i = 0;
    s_data_i = '0;
    s_weight_i = '0;
    s_last_i = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: len=4 basic vector
    step(1, 8'd1, 8'd2, 0, 7'd4, e);
    step(1, 8'd3, 8'd4, 0, 7'd4, e);
    step(1, 8'd5, 8'd6, 0, 7'd4, e);
    step(1, 8'd7, 8'd8, 0, 7'd4, e);
    chk("t1_emitted", 512'(e), 512'(1));

    // 2: len=8 closed early by last on beat 3, next packs from lane 0
    step(1, 8'($urandom), 8'($urandom), 0, 7'd8, e);
    step(1, 8'($urandom), 8'($urandom), 0, 7'd2, e);
    step(1, 8'($urandom), 8'($urandom), 1, 7'd1, e);
    chk("t2_emitted", 512'(e), 512'(1));
    step(1, 8'hA5, 8'h5A, 0, 7'd2, e);
    step(1, 8'h3C, 8'hC3, 0, 7'd9, e);
    chk("t2_next", 512'(e), 512'(1));

    // 3: cfg_len=0 clamps to 64 and sets sticky error
    for (int i = 0; i < 64; i++)
      step(1, 8'($urandom), 8'($urandom), 0, (i == 0) ? 7'd0 : 7'd3, e);
    chk("t3_emitted", 512'(e), 512'(1));
    step(1, 8'd9, 8'd9, 0, 7'd1, e);
    chk("t3_err_sticky", 512'(cfg_err_o), 512'(1));
    step(1, 8'd9, 8'd9, 0, 7'd100, e);
    step(1, 8'd9, 8'd9, 1, 7'd1, e);
    do_reset();

    // 4: gaps in s_valid
    step(1, 8'd11, 8'd21, 0, 7'd4, e);
    step(0, 8'd99, 8'd99, 0, 7'd4, e);
    step(0, 8'd98, 8'd98, 1, 7'd4, e);
    step(1, 8'd12, 8'd22, 0, 7'd4, e);
    step(1, 8'd13, 8'd23, 0, 7'd4, e);
    step(0, 8'd97, 8'd97, 0, 7'd4, e);
    step(1, 8'd14, 8'd24, 0, 7'd4, e);
    chk("t4_vcnt", 512'(vec_cnt_o), 512'(1));

    // 5: reset in the middle of a fill
    do_reset();
    step(1, 8'd1, 8'd1, 0, 7'd4, e);
    step(1, 8'd2, 8'd2, 0, 7'd4, e);
    do_reset();
    idle(2);
    for (int i = 0; i < 4; i++)
      step(1, 8'($urandom), 8'($urandom), 0, 7'd4, e);
    chk("t5_vcnt", 512'(vec_cnt_o), 512'(1));

    // 6: stale vs zero-filled upper lanes
    for (int i = 0; i < 4; i++)
      step(1, 8'h7F, 8'h7F, 0, 7'd4, e);
    step(1, 8'h01, 8'h02, 0, 7'd2, e);
    step(1, 8'h03, 8'h04, 0, 7'd2, e);

    // random streams
    for (int vv = 0; vv < 40; vv++) begin
      if ($urandom_range(0, 9) == 0) cfg = 7'($urandom_range(0, 70));
      else cfg = 7'($urandom_range(1, 8));
      got = 0;
      guard = 0;
      while (!got && guard < 300) begin
        d0 = 8'($urandom);
        w0 = 8'($urandom);
        step($urandom_range(0, 9) < 7, d0, w0, $urandom_range(0, 9) == 0,
             in_vec ? 7'($urandom) : cfg, got);
        guard++;
      end
      if (!got) chk("rand_timeout", 512'(0), 512'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
